// File: rtl/regs_pkg.sv
// rtl/regs_pkg.sv - shared constants and types for the RV32I register file
//
// Purpose : address/data bus types and well-known constants used by regs
//           and regs_rport.
// Ports   : none (package)
package regs_pkg;

   localparam int          RegNum       = 32;
   localparam logic [31:0] ZeroWord     = 32'h0;
   localparam logic [4:0]  ZeroReg      = 5'h0;
   localparam logic        WriteEnable  = 1'b1;
   localparam logic        WriteDisable = 1'b0;

   typedef logic [4:0]  reg_addr_t;   // RegAddrBus (4:0)
   typedef logic [31:0] reg_bus_t;    // RegBus (31:0)

endpackage

// File: rtl/regs_rport.sv
// rtl/regs_rport.sv - one combinational read port of the register file
//
// Purpose : x0 check, write-to-read bypass compare and storage select.
// Ports   : raddr_i   read address
//           byp_en_i  a write is being presented this cycle (and not in reset)
//           waddr_i   address of the write being presented
//           wdata_i   data of the write being presented
//           regs_i    committed storage
//           rdata_o   read data
module regs_rport
   import regs_pkg::*;
#(
   parameter int REG_NUM = RegNum,
   parameter int REG_W   = 32
) (
   input  logic [4:0]                    raddr_i,
   input  logic                          byp_en_i,
   input  logic [4:0]                    waddr_i,
   input  logic [REG_W-1:0]              wdata_i,
   input  logic [REG_NUM-1:0][REG_W-1:0] regs_i,
   output logic [REG_W-1:0]              rdata_o
);

   always_comb begin
      rdata_o = '0;
      if (raddr_i == ZeroReg) begin
         rdata_o = '0;
      end else if (byp_en_i && (waddr_i == raddr_i)) begin
         rdata_o = wdata_i;
      end else begin
         rdata_o = regs_i[raddr_i];
      end
   end

endmodule

// File: rtl/regs.sv
// rtl/regs.sv - 32 x 32-bit RV32I integer register file with bypass
//
// Purpose : write-back commit from ex, two combinational bypassed read ports
//           for id, committed-write counter and x0-write flag.
//           Optional registered debug read port when REGS_DBG_EN is defined.
// Ports   : clk, rst            clock, async active-high reset
//           reg_waddr_i/wdata_i/wen_i   write from ex
//           reg1_raddr_i, reg2_raddr_i  read addresses from id
//           reg1_rdata_o, reg2_rdata_o  read data
//           wcnt_o              committed writes to x1..x31 (wraps)
//           wr_x0_o             previous cycle attempted a write to x0
//           dbg_raddr_i, dbg_rdata_o    (REGS_DBG_EN only) registered debug read
module regs
   import regs_pkg::*;
#(
   parameter int REG_NUM = RegNum,
   parameter int REG_W   = 32,
   parameter int WCNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        reg_waddr_i,
   input  logic [REG_W-1:0]  reg_wdata_i,
   input  logic              reg_wen_i,
   input  logic [4:0]        reg1_raddr_i,
   input  logic [4:0]        reg2_raddr_i,
   output logic [REG_W-1:0]  reg1_rdata_o,
   output logic [REG_W-1:0]  reg2_rdata_o,
   output logic [WCNT_W-1:0] wcnt_o,
`ifdef REGS_DBG_EN
   input  logic [4:0]        dbg_raddr_i,
   output logic [REG_W-1:0]  dbg_rdata_o,
`endif
   output logic              wr_x0_o
);

   logic [REG_NUM-1:0][REG_W-1:0] regs_q;
   logic [WCNT_W-1:0]             wcnt_q, wcnt_d;
   logic                          wr_x0_q, wr_x0_d;
   logic                          commit;
   logic                          byp_en;

   assign commit  = (reg_wen_i == WriteEnable) && (reg_waddr_i != ZeroReg);
   // Bypass is suppressed during reset so reads return the cleared storage.
   assign byp_en  = (reg_wen_i == WriteEnable) && !rst;
   assign wcnt_d  = commit ? wcnt_q + WCNT_W'(1) : wcnt_q;
   assign wr_x0_d = (reg_wen_i == WriteEnable) && (reg_waddr_i == ZeroReg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q  <= '0;
         wcnt_q  <= '0;
         wr_x0_q <= 1'b0;
      end else begin
         if (commit) begin
            regs_q[reg_waddr_i] <= reg_wdata_i;
         end
         wcnt_q  <= wcnt_d;
         wr_x0_q <= wr_x0_d;
      end
   end

   assign wcnt_o  = wcnt_q;
   assign wr_x0_o = wr_x0_q;

   regs_rport #(.REG_NUM(REG_NUM), .REG_W(REG_W)) u_rport1 (
      .raddr_i  (reg1_raddr_i),
      .byp_en_i (byp_en),
      .waddr_i  (reg_waddr_i),
      .wdata_i  (reg_wdata_i),
      .regs_i   (regs_q),
      .rdata_o  (reg1_rdata_o)
   );

   regs_rport #(.REG_NUM(REG_NUM), .REG_W(REG_W)) u_rport2 (
      .raddr_i  (reg2_raddr_i),
      .byp_en_i (byp_en),
      .waddr_i  (reg_waddr_i),
      .wdata_i  (reg_wdata_i),
      .regs_i   (regs_q),
      .rdata_o  (reg2_rdata_o)
   );

`ifdef REGS_DBG_EN
   // Debug read shows committed storage only, one cycle after the address.
   logic [REG_W-1:0] dbg_rdata_q, dbg_rdata_d;

   assign dbg_rdata_d = (dbg_raddr_i == ZeroReg) ? '0 : regs_q[dbg_raddr_i];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg_rdata_q <= '0;
      end else begin
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign dbg_rdata_o = dbg_rdata_q;
`endif

endmodule

// File: tb/tb_regs.sv
// tb/tb_regs.sv - directed self-checking bench for regs
module tb_regs;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  reg_waddr_i  = '0;
   logic [31:0] reg_wdata_i  = '0;
   logic        reg_wen_i    = 1'b0;
   logic [4:0]  reg1_raddr_i = '0;
   logic [4:0]  reg2_raddr_i = '0;
   logic [31:0] reg1_rdata_o, reg2_rdata_o;
   logic [1:0]  wcnt_o;
   logic        wr_x0_o;
`ifdef REGS_DBG_EN
   logic [4:0]  dbg_raddr_i = '0;
   logic [31:0] dbg_rdata_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   regs #(.REG_NUM(32), .REG_W(32), .WCNT_W(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .reg_waddr_i  (reg_waddr_i),
      .reg_wdata_i  (reg_wdata_i),
      .reg_wen_i    (reg_wen_i),
      .reg1_raddr_i (reg1_raddr_i),
      .reg2_raddr_i (reg2_raddr_i),
      .reg1_rdata_o (reg1_rdata_o),
      .reg2_rdata_o (reg2_rdata_o),
      .wcnt_o       (wcnt_o),
`ifdef REGS_DBG_EN
      .dbg_raddr_i  (dbg_raddr_i),
      .dbg_rdata_o  (dbg_rdata_o),
`endif
      .wr_x0_o      (wr_x0_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      reg_wen_i   = 1'b1;
      reg_waddr_i = a;
      reg_wdata_i = d;
      step();
      reg_wen_i   = 1'b0;
   endtask

   initial begin
      // Reset state
      step();
      step();
      reg1_raddr_i = 5'd5;
      reg2_raddr_i = 5'd31;
      #1;
      check("rst_rd1", reg1_rdata_o, 32'h0);
      check("rst_rd2", reg2_rdata_o, 32'h0);
      check("rst_wcnt", {30'h0, wcnt_o}, 32'h0);
      check("rst_wrx0", {31'h0, wr_x0_o}, 32'h0);
      rst = 1'b0;
      step();

      // Write x5, then async reset mid-cycle clears it without a clock edge
      wr(5'd5, 32'h1234);
      check("x5_rd", reg1_rdata_o, 32'h1234);
      check("x5_wcnt", {30'h0, wcnt_o}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_x5", reg1_rdata_o, 32'h0);
      check("arst_wcnt", {30'h0, wcnt_o}, 32'h0);
      // Write during reset: no bypass, no commit
      reg_wen_i   = 1'b1;
      reg_waddr_i = 5'd5;
      reg_wdata_i = 32'hFF;
      #1;
      check("rst_nobyp", reg1_rdata_o, 32'h0);
      step();
      reg_wen_i = 1'b0;
      check("rst_wr_lost", reg1_rdata_o, 32'h0);
      check("rst_wr_wcnt", {30'h0, wcnt_o}, 32'h0);
      rst = 1'b0;
      step();

      // Write/readback x3
      wr(5'd3, 32'hDEAD_BEEF);
      reg1_raddr_i = 5'd3;
      #1;
      check("x3_rd", reg1_rdata_o, 32'hDEAD_BEEF);
      check("x3_wcnt", {30'h0, wcnt_o}, 32'h1);

      // Same-cycle bypass on both ports
      reg_wen_i    = 1'b1;
      reg_waddr_i  = 5'd7;
      reg_wdata_i  = 32'h55;
      reg1_raddr_i = 5'd7;
      reg2_raddr_i = 5'd7;
      #1;
      check("byp_rd1", reg1_rdata_o, 32'h55);
      check("byp_rd2", reg2_rdata_o, 32'h55);
      reg2_raddr_i = 5'd3;
      #1;
      check("byp_other", reg2_rdata_o, 32'hDEAD_BEEF);
      step();
      reg_wen_i    = 1'b0;
      reg2_raddr_i = 5'd7;
      #1;
      check("x7_rd1", reg1_rdata_o, 32'h55);
      check("x7_rd2", reg2_rdata_o, 32'h55);
      check("x7_wcnt", {30'h0, wcnt_o}, 32'h2);

      // x0 write is discarded, flagged for one cycle
      reg_wen_i    = 1'b1;
      reg_waddr_i  = 5'd0;
      reg_wdata_i  = 32'hFFFF_FFFF;
      reg1_raddr_i = 5'd0;
      #1;
      check("x0_same", reg1_rdata_o, 32'h0);
      check("x0_flag_pre", {31'h0, wr_x0_o}, 32'h0);
      step();
      reg_wen_i = 1'b0;
      check("x0_next", reg1_rdata_o, 32'h0);
      check("x0_flag", {31'h0, wr_x0_o}, 32'h1);
      check("x0_wcnt", {30'h0, wcnt_o}, 32'h2);
      step();
      check("x0_flag_clr", {31'h0, wr_x0_o}, 32'h0);

      // wen=0: address/data ignored, no bypass, no count
      reg_waddr_i  = 5'd3;
      reg_wdata_i  = 32'h123;
      reg1_raddr_i = 5'd3;
      #1;
      check("nowen_nobyp", reg1_rdata_o, 32'hDEAD_BEEF);
      step();
      check("nowen_store", reg1_rdata_o, 32'hDEAD_BEEF);
      check("nowen_wcnt", {30'h0, wcnt_o}, 32'h2);

      // Back-to-back x9=1 then x9=2; counter 2->4 wraps to 0 (WCNT_W=2)
      reg1_raddr_i = 5'd9;
      wr(5'd9, 32'h1);
      reg_wen_i   = 1'b1;
      reg_waddr_i = 5'd9;
      reg_wdata_i = 32'h2;
      #1;
      check("b2b_byp", reg1_rdata_o, 32'h2);
      step();
      reg_wen_i = 1'b0;
      check("b2b_rd", reg1_rdata_o, 32'h2);
      check("b2b_wcnt", {30'h0, wcnt_o}, 32'h0);

      // Four more writes wrap again to 0, a fifth gives 1
      for (int i = 0; i < 4; i++) wr(5'(10 + i), 32'h100 + 32'(i));
      check("wrap_wcnt", {30'h0, wcnt_o}, 32'h0);
      reg2_raddr_i = 5'd13;
      #1;
      check("x13_rd", reg2_rdata_o, 32'h103);
      wr(5'd14, 32'hABCD);
      check("wrap_wcnt1", {30'h0, wcnt_o}, 32'h1);

`ifdef REGS_DBG_EN
      wr(5'd12, 32'hA5A5);
      dbg_raddr_i = 5'd12;
      #1;
      check("dbg_lat0", dbg_rdata_o, 32'h0);
      step();
      check("dbg_rd", dbg_rdata_o, 32'hA5A5);
      dbg_raddr_i = 5'd0;
      step();
      check("dbg_x0", dbg_rdata_o, 32'h0);
      // Debug read ignores bypass
      dbg_raddr_i = 5'd20;
      reg_wen_i   = 1'b1;
      reg_waddr_i = 5'd20;
      reg_wdata_i = 32'h77;
      step();
      reg_wen_i = 1'b0;
      check("dbg_nobyp", dbg_rdata_o, 32'h0);
      step();
      check("dbg_x20", dbg_rdata_o, 32'h77);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
